// File: rtl/zap_wb_merger.sv
// Purpose: merges the code-side and data-side cache bus requests onto one registered Wishbone master port.
// Latency: bus outputs follow the selected cache *_nxt request by exactly one clock; acks and read data are combinational.
// Backpressure: the owner keeps the bus until it drops cyc_nxt; the other side's request stays pending with no timeout.
module zap_wb_merger #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_code_wb_cyc_nxt,
    input  logic        i_code_wb_stb_nxt,
    input  logic        i_code_wb_wen_nxt,
    input  logic [3:0]  i_code_wb_sel_nxt,
    input  logic [31:0] i_code_wb_dat_nxt,
    input  logic [31:0] i_code_wb_adr_nxt,
    input  logic [2:0]  i_code_wb_cti_nxt,
    output logic        o_code_wb_ack,

    input  logic        i_data_wb_cyc_nxt,
    input  logic        i_data_wb_stb_nxt,
    input  logic        i_data_wb_wen_nxt,
    input  logic [3:0]  i_data_wb_sel_nxt,
    input  logic [31:0] i_data_wb_dat_nxt,
    input  logic [31:0] i_data_wb_adr_nxt,
    input  logic [2:0]  i_data_wb_cti_nxt,
    output logic        o_data_wb_ack,

    output logic [31:0] o_wb_dat_rd,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic [31:0] o_wb_adr,
    output logic [2:0]  o_wb_cti,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack
);

    // Bus ownership states; last_grant_ff reuses the CODE/DATA encodings.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CODE = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    // One complete Wishbone request, so the output mux and register stay one wide word.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [2:0]  cti;
    } wb_req_t;

    wb_req_t    code_req;
    wb_req_t    data_req;
    wb_req_t    bus_nxt;
    wb_req_t    bus_ff;

    logic [1:0] state_ff;
    logic [1:0] state_nxt;
    logic [1:0] last_grant_ff;
    logic       both_req;
    logic       data_wins;

    assign code_req = '{
        cyc: i_code_wb_cyc_nxt,
        stb: i_code_wb_stb_nxt,
        wen: i_code_wb_wen_nxt,
        sel: i_code_wb_sel_nxt,
        dat: i_code_wb_dat_nxt,
        adr: i_code_wb_adr_nxt,
        cti: i_code_wb_cti_nxt
    };

    assign data_req = '{
        cyc: i_data_wb_cyc_nxt,
        stb: i_data_wb_stb_nxt,
        wen: i_data_wb_wen_nxt,
        sel: i_data_wb_sel_nxt,
        dat: i_data_wb_dat_nxt,
        adr: i_data_wb_adr_nxt,
        cti: i_data_wb_cti_nxt
    };

    // On a tie, data wins under fixed priority; otherwise the side not served last time wins.
    assign both_req  = i_code_wb_cyc_nxt & i_data_wb_cyc_nxt;
    assign data_wins = (FIXED_PRIORITY != 0) || (last_grant_ff == CODE);

    // Ownership is only granted from IDLE, so a handover always passes through one cyc-low cycle.
    always_comb begin
        state_nxt = state_ff;
        case (state_ff)
            IDLE: begin
                if (both_req) begin
                    state_nxt = data_wins ? DATA : CODE;
                end else if (i_code_wb_cyc_nxt) begin
                    state_nxt = CODE;
                end else if (i_data_wb_cyc_nxt) begin
                    state_nxt = DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            // The owner keeps the bus for the whole cycle, bursts included.
            CODE:    state_nxt = i_code_wb_cyc_nxt ? CODE : IDLE;
            DATA:    state_nxt = i_data_wb_cyc_nxt ? DATA : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Select the request of whoever owns the bus next cycle; an idle bus drives all zeros.
    always_comb begin
        bus_nxt = '0;
        case (state_nxt)
            CODE:    bus_nxt = code_req;
            DATA:    bus_nxt = data_req;
            default: bus_nxt = '0;
        endcase
    end

    // Ownership state and the round-robin history, updated on every grant out of IDLE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_ff      <= IDLE;
            last_grant_ff <= CODE;
        end else begin
            state_ff <= state_nxt;
            if ((state_ff == IDLE) && (state_nxt != IDLE)) begin
                last_grant_ff <= state_nxt;
            end
        end
    end

    // Registered external bus; reset releases it immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus_ff <= '0;
        end else begin
            bus_ff <= bus_nxt;
        end
    end

    assign o_wb_cyc = bus_ff.cyc;
    assign o_wb_stb = bus_ff.stb;
    assign o_wb_wen = bus_ff.wen;
    assign o_wb_sel = bus_ff.sel;
    assign o_wb_dat = bus_ff.dat;
    assign o_wb_adr = bus_ff.adr;
    assign o_wb_cti = bus_ff.cti;

    // Acks go only to the current owner; an ack seen while idle is dropped.
    assign o_code_wb_ack = i_wb_ack & (state_ff == CODE);
    assign o_data_wb_ack = i_wb_ack & (state_ff == DATA);

    // Read data is broadcast; each cache qualifies it with its own ack.
    assign o_wb_dat_rd = i_wb_dat;

endmodule

// File: doc/zap_wb_merger.md
Name: zap_wb_merger

Overview:
- Two-master Wishbone arbiter that sits directly downstream of the instruction-side and data-side zap_cache instances.
- Consumes each cache's combinational next-cycle bus request (o_wb_*_nxt) and produces one registered external Wishbone master port.
- Arbitrates between the two requesters and holds ownership for a whole cycle (cyc) so bursts are never split.
- Routes ack back to the owning cache and broadcasts read data to both.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between code and data; 1 = data always wins at arbitration points.

Ports:
i_clk  input  1  core clock
i_reset_n  input  1  reset, asynchronous, active-low
i_code_wb_cyc_nxt  input  1  code-side next cyc
i_code_wb_stb_nxt  input  1  code-side next stb
i_code_wb_wen_nxt  input  1  code-side next write enable
i_code_wb_sel_nxt  input  4  code-side next byte select
i_code_wb_dat_nxt  input  32  code-side next write data
i_code_wb_adr_nxt  input  32  code-side next address
i_code_wb_cti_nxt  input  3  code-side next cycle type
o_code_wb_ack  output  1  ack routed to code side
i_data_wb_cyc_nxt .. i_data_wb_cti_nxt  input  1/1/1/4/32/32/3  data-side equivalents of the seven code-side inputs
o_data_wb_ack  output  1  ack routed to data side
o_wb_dat_rd  output  32  i_wb_dat passed through combinationally to both sides
o_wb_cyc, o_wb_stb, o_wb_wen  output  1 each  registered external bus controls
o_wb_sel  output  4  registered byte select
o_wb_dat  output  32  registered write data
o_wb_adr  output  32  registered address
o_wb_cti  output  3  registered cycle type
i_wb_dat  input  32  external read data
i_wb_ack  input  1  external ack

Behaviour:
- **Reset.** i_reset_n low asynchronously forces:
  - state_ff = IDLE
  - last_grant_ff = CODE
  - all o_wb_* = 0 (o_wb_cti = 3'b000, classic)
- **Acks.** Both acks are combinational from state_ff, so they read 0 during reset and never assert while state_ff = IDLE.
- **Output timing.**
  - States: IDLE, CODE, DATA.
  - Every output register loads the selected side's *_nxt inputs each cycle, with selection by state_nxt.
  - When state_nxt = IDLE, the registers load all zeros (cti = 0).
  - Bus outputs therefore lag the cache *_nxt by exactly 1 cycle.
- **IDLE transitions.**
  - Neither cyc_nxt high: stay IDLE.
  - Only one side's cyc_nxt high: go to that side.
  - Both high, FIXED_PRIORITY = 1: go to DATA.
  - Both high, FIXED_PRIORITY = 0: grant the side opposite last_grant_ff.
  - On every grant, last_grant_ff <= the granted side.
- **CODE transitions.** Stay while i_code_wb_cyc_nxt = 1, regardless of data requests. Go to IDLE when it drops.
- **DATA transitions.** Mirror of CODE. There is no direct CODE<->DATA transition, which guarantees at least one cycle of o_wb_cyc = 0 between ownerships.
- **Ack routing.**
  - o_code_wb_ack = i_wb_ack & (state_ff == CODE).
  - o_data_wb_ack = i_wb_ack & (state_ff == DATA).
  - An ack arriving while state_ff = IDLE is discarded.
  - o_wb_dat_rd = i_wb_dat, no gating.
- **Bursts.** cti and adr are forwarded unmodified. A burst ends only when the owner drops cyc_nxt; a cti = 3'b111 beat does not by itself release the grant.
- **Simultaneous events.** If the owner drops cyc_nxt in the same cycle the other side raises it: IDLE for 1 cycle, then grant. The pending side's *_nxt must stay stable until acked; the caches already guarantee this.
- **Reset mid-burst.** Bus released immediately (asynchronous). No ack is delivered afterwards. Both caches are reset by the same event.
- **Stall.** stb held with no i_wb_ack keeps the grant indefinitely. There is no timeout.

Test Plan:
1. **Code-only single read.**
   - Stimulus: code cyc/stb_nxt=1, adr_nxt=0x0000_1000 until ack; ack on bus cycle 3.
   - Required response:
     - o_wb_adr = 0x1000 and o_wb_cyc = 1 one cycle after request.
     - o_code_wb_ack = 1 for one cycle, o_data_wb_ack = 0 throughout.
     - o_wb_cyc = 0 the cycle after the code side drops.
2. **Simultaneous request out of reset, FIXED_PRIORITY = 0.**
   - Stimulus: code adr 0x100 and data adr 0x200 raised together.
   - Required response:
     - DATA granted first (adr 0x200).
     - After the data drop: one IDLE cycle with o_wb_cyc = 0, then adr 0x100.
     - A repeat of the simultaneous request then grants CODE first.
3. **Four-beat code burst with data request mid-burst.**
   - Stimulus:
     - Code burst: cti 010,010,010,111; adr 0x40,0x44,0x48,0x4C.
     - Data request raised at beat 2.
   - Required response:
     - All 4 beats on the bus uninterrupted, acks to code only.
     - Data granted 2 cycles after the code drop (one IDLE cycle).
4. **FIXED_PRIORITY = 1.**
   - Stimulus: both sides requesting continuously, each single beat then drop, then re-raise.
   - Required response: DATA wins every arbitration.
5. **Async reset mid-burst.**
   - Stimulus: pull i_reset_n low between clock edges during beat 2 of a data burst while i_wb_ack = 1.
   - Required response:
     - o_wb_cyc/stb/adr = 0 immediately.
     - Both acks = 0, and no acks after reset release.
     - First post-reset simultaneous request grants DATA.
6. **Stray ack while IDLE.**
   - Stimulus: i_wb_ack = 1 with no requests.
   - Required response: both acks stay 0 and the state remains IDLE.
